bin_dec_strobe: RTL and testbench

//   Registered binary-to-one-hot decoder with valid/ready input handshake and a

---
 rtl/bin_dec_strobe.sv | 153 +++++++++++++++
 tb/tb_bin_dec_strobe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_dec_strobe.sv
// bin_dec_strobe: registered binary-to-one-hot decoder with a valid/ready input
// handshake and a programmable strobe hold time.
//
// An accepted W-bit code drives line y[code] for HOLD_CYC cycles (one cycle of
// latency), after which all lines return to zero for at least one cycle before
// the next code can be taken.
//
// Handshake: a code transfers on a rising edge where in_valid && in_ready && !clr.
// in_ready depends only on the FSM state (high in IDLE), never on in_valid. While
// a strobe is held, in_valid is ignored and the source keeps its data stable.
//
// Optional feature: define DEC_PARITY_EN to add the in_par port (even parity over
// in_code). A code with bad parity is consumed but not decoded, and err pulses
// for one cycle. Without the macro, err is tied low and no parity logic exists.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = HOLD) for checkers.

module bin_dec_strobe #(
    parameter int W        = 3,
    parameter int HOLD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_code,
`ifdef DEC_PARITY_EN
    input  logic               in_par,
`endif
    output logic [(1<<W)-1:0]  y,
    output logic               y_valid,
    output logic               err,
    output logic               dbg_state
);

    localparam int N = 1 << W;
    // Counter load value: the accept cycle itself is not counted, so a strobe of
    // HOLD_CYC cycles leaves HOLD after the cycle in which cnt reaches zero.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    y_q, y_d;
    logic            y_valid_q, y_valid_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            load_ok;
    logic [N-1:0]    onehot;

    // The shift is done at full output width so the top code lands on the MSB.
    assign onehot = {{(N-1){1'b0}}, 1'b1} << in_code;

`ifdef DEC_PARITY_EN
    logic err_q, err_d;
    logic par_bad;

    // Even parity over {code, parity bit}: an odd total means a corrupted code.
    assign par_bad = ^{in_code, in_par};
    assign load_ok = ~par_bad;
`else
    assign load_ok = 1'b1;
`endif

    // Next-state and next-output logic; clr overrides everything.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        cnt_d     = cnt_q;
`ifdef DEC_PARITY_EN
        err_d     = 1'b0;
`endif
        if (clr) begin
            state_d   = IDLE;
            y_d       = '0;
            y_valid_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (load_ok) begin
                            y_d       = onehot;
                            y_valid_d = 1'b1;
                            cnt_d     = HOLD_LOAD;
                            state_d   = HOLD;
                        end
`ifdef DEC_PARITY_EN
                        else begin
                            err_d = 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        y_d       = '0;
                        y_valid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    cnt_d     = '0;
                end
            endcase
        end
    end

    // State and output registers; reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef DEC_PARITY_EN
    // Parity error flag, a one-cycle pulse following a bad-parity accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign dbg_state = (state_q == HOLD);

endmodule

// File: tb/tb_bin_dec_strobe.sv
// Bench for bin_dec_strobe. Two instances share the clock: instance 0 holds
// strobes for 3 cycles, instance 1 for 1 cycle. A behavioural model tracks, per
// instance, how many strobe cycles remain and which code is being shown; every
// falling edge the outputs of both instances are compared against it. Directed
// sequences add hand-computed literal expectations.

module tb_bin_dec_strobe;

    localparam int W      = 3;
    localparam int N      = 1 << W;
    localparam int HOLD_A = 3;
    localparam int HOLD_B = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         clr      [2];
    logic         in_valid [2];
    logic [W-1:0] in_code  [2];
    logic         in_par   [2];
    logic         in_ready [2];
    logic [N-1:0] y        [2];
    logic         y_valid  [2];
    logic         err      [2];
    logic         dbg      [2];

    logic [N-1:0] y_a, y_b;
    logic         rdy_a, rdy_b, yv_a, yv_b, err_a, err_b, dbg_a, dbg_b;

    bin_dec_strobe #(.W(W), .HOLD_CYC(HOLD_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (rdy_a),
        .in_code   (in_code[0]),
`ifdef DEC_PARITY_EN
        .in_par    (in_par[0]),
`endif
        .y         (y_a),
        .y_valid   (yv_a),
        .err       (err_a),
        .dbg_state (dbg_a)
    );

    bin_dec_strobe #(.W(W), .HOLD_CYC(HOLD_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (rdy_b),
        .in_code   (in_code[1]),
`ifdef DEC_PARITY_EN
        .in_par    (in_par[1]),
`endif
        .y         (y_b),
        .y_valid   (yv_b),
        .err       (err_b),
        .dbg_state (dbg_b)
    );

    assign y[0] = y_a;        assign y[1] = y_b;
    assign in_ready[0] = rdy_a; assign in_ready[1] = rdy_b;
    assign y_valid[0] = yv_a; assign y_valid[1] = yv_b;
    assign err[0] = err_a;    assign err[1] = err_b;
    assign dbg[0] = dbg_a;    assign dbg[1] = dbg_b;

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rem: strobe cycles still to be shown (0 = idle, ready for a new code).
    int           rem   [2];
    logic [W-1:0] mcode [2];
    logic         merr  [2];

    function automatic int hold_of(input int i);
        return (i == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic logic bad_parity(input logic [W-1:0] c, input logic p);
`ifdef DEC_PARITY_EN
        return ^{c, p};
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rem[i]   <= 0;
                mcode[i] <= '0;
                merr[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                merr[i] <= 1'b0;
                if (clr[i]) begin
                    rem[i] <= 0;
                end else if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                end else if (in_valid[i]) begin
                    if (bad_parity(in_code[i], in_par[i])) begin
                        merr[i] <= 1'b1;
                    end else begin
                        rem[i]   <= hold_of(i);
                        mcode[i] <= in_code[i];
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [N-1:0] ey;
            ey = (rem[i] > 0) ? (N'(1) << mcode[i]) : '0;
            chk($sformatf("u%0d.y", i), 32'(y[i]), 32'(ey));
            chk($sformatf("u%0d.y_valid", i), 32'(y_valid[i]), 32'(ey != '0));
            chk($sformatf("u%0d.in_ready", i), 32'(in_ready[i]), 32'(rem[i] == 0));
            chk($sformatf("u%0d.dbg_state", i), 32'(dbg[i]), 32'(rem[i] > 0));
            chk($sformatf("u%0d.err", i), 32'(err[i]), 32'(merr[i]));
            chk($sformatf("u%0d.onehot", i), 32'($countones(y[i]) <= 1), 32'd1);
            chk($sformatf("u%0d.yv_eq_or", i), 32'(y_valid[i]), 32'(|y[i]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle of an instance against literal values, then advance.
    task automatic expect_cyc(input string nm, input int i, input logic [N-1:0] ey, input logic er);
        @(negedge clk);
        chk({nm, ".y"}, 32'(y[i]), 32'(ey));
        chk({nm, ".ready"}, 32'(in_ready[i]), 32'(er));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] c, input logic p);
        in_valid[i] = v;
        in_code[i]  = c;
        in_par[i]   = p;
    endtask

    // ---------------- directed stimulus ----------------
    logic [N-1:0] seq3_y [8];
    logic         seq3_r [8];

    initial begin
        seq3_y = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00};
        seq3_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0;
            drive(i, 1'b0, '0, 1'b0);
        end
        // Test 1: reset held with in_valid high.
        rst_n = 1'b0;
        drive(0, 1'b1, 3'd5, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst.y", 32'(y_a), 32'h0);
        chk("rst.y_valid", 32'(yv_a), 32'h0);
        chk("rst.err", 32'(err_a), 32'h0);
        chk("rst.in_ready", 32'(rdy_a), 32'h1);
        step();
        drive(0, 1'b0, 3'd5, 1'b0);
        rst_n = 1'b1;
        expect_cyc("post_rst0", 0, 8'h00, 1'b1);
        expect_cyc("post_rst1", 0, 8'h00, 1'b1);

        // Test 2: code 5, 3-cycle hold.
        drive(0, 1'b1, 3'd5, 1'b0);
        step();
        drive(0, 1'b0, 3'd0, 1'b0);
        expect_cyc("c5_k1", 0, 8'h20, 1'b0);
        expect_cyc("c5_k2", 0, 8'h20, 1'b0);
        expect_cyc("c5_k3", 0, 8'h20, 1'b0);
        expect_cyc("c5_k4", 0, 8'h00, 1'b1);

        // Test 3: code 2 twice with in_valid held high.
        drive(0, 1'b1, 3'd2, 1'b0);
        step();
        for (int j = 0; j < 8; j++)
            expect_cyc($sformatf("b2b_%0d", j), 0, seq3_y[j], seq3_r[j]);
        drive(0, 1'b0, 3'd0, 1'b0);
        repeat (4) step();

        // Test 4: clr in the 2nd hold cycle of code 7, then code 0.
        drive(0, 1'b1, 3'd7, 1'b0);
        step();
        drive(0, 1'b0, 3'd0, 1'b0);
        expect_cyc("c7_h1", 0, 8'h80, 1'b0);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        drive(0, 1'b1, 3'd0, 1'b0);
        expect_cyc("clr_after", 0, 8'h00, 1'b1);
        drive(0, 1'b0, 3'd0, 1'b0);
        expect_cyc("c0_after_clr", 0, 8'h01, 1'b0);
        repeat (3) step();

        // clr together with a valid code in IDLE: nothing accepted.
        clr[0] = 1'b1;
        drive(0, 1'b1, 3'd4, 1'b0);
        step();
        clr[0] = 1'b0;
        drive(0, 1'b0, 3'd0, 1'b0);
        expect_cyc("clr_blocks", 0, 8'h00, 1'b1);

        // Test 5: sweep all codes on the single-cycle instance.
        for (int c = 0; c < N; c++) begin
            drive(1, 1'b1, 3'(c), 1'b0);
            step();
            drive(1, 1'b0, 3'd0, 1'b0);
            expect_cyc($sformatf("sweep%0d", c), 1, 8'(1 << c), 1'b0);
            expect_cyc($sformatf("sweep%0d_gap", c), 1, 8'h00, 1'b1);
        end

`ifdef DEC_PARITY_EN
        // Test 6: bad parity then good parity on code 3.
        drive(0, 1'b1, 3'd3, 1'b1);
        step();
        drive(0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("par_bad.err", 32'(err_a), 32'h1);
        chk("par_bad.y", 32'(y_a), 32'h0);
        chk("par_bad.ready", 32'(rdy_a), 32'h1);
        step();
        @(negedge clk);
        chk("par_bad.err_drop", 32'(err_a), 32'h0);
        step();
        drive(0, 1'b1, 3'd3, 1'b0);
        step();
        drive(0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("par_ok.y", 32'(y_a), 32'h08);
        chk("par_ok.err", 32'(err_a), 32'h0);
        repeat (4) step();
`endif

        // Asynchronous reset in the middle of a hold.
        drive(0, 1'b1, 3'd6, 1'b0);
        step();
        drive(0, 1'b0, 3'd0, 1'b0);
        step();
        #2;
        chk("pre_async.y", 32'(y_a), 32'h40);
        rst_n = 1'b0;
        #1;
        chk("async_rst.y", 32'(y_a), 32'h0);
        chk("async_rst.y_valid", 32'(yv_a), 32'h0);
        chk("async_rst.ready", 32'(rdy_a), 32'h1);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
